// File: rtl/conv_feed_if.sv
// Memory, accumulator and result bus between the window feeder and its
// surroundings: feature-map/kernel reads, accumulator beats, result writes.
interface conv_feed_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic [AW-1:0]   fm_addr;
  logic [3*DW-1:0] fm_data;
  logic [AW-1:0]   w_addr;
  logic [3*DW-1:0] w_data;
  logic            en;
  logic [9:0]      Size;
  logic [DW-1:0]   D_in_R;
  logic [DW-1:0]   D_in_G;
  logic [DW-1:0]   D_in_B;
  logic [DW-1:0]   Weight_R;
  logic [DW-1:0]   Weight_G;
  logic [DW-1:0]   Weight_B;
  logic [DW-1:0]   Bias;
  logic [31:0]     Conv_out_R;
  logic [31:0]     Conv_out_G;
  logic [31:0]     Conv_out_B;
  logic            conv_ack;
  logic            res_we;
  logic [AW-1:0]   res_addr;
  logic [31:0]     res_data;

  modport master (
    output fm_addr, w_addr, en, Size,
    output D_in_R, D_in_G, D_in_B,
    output Weight_R, Weight_G, Weight_B, Bias,
    output res_we, res_addr, res_data,
    input  fm_data, w_data,
    input  Conv_out_R, Conv_out_G, Conv_out_B, conv_ack
  );

  modport slave (
    input  fm_addr, w_addr, en, Size,
    input  D_in_R, D_in_G, D_in_B,
    input  Weight_R, Weight_G, Weight_B, Bias,
    input  res_we, res_addr, res_data,
    output fm_data, w_data,
    output Conv_out_R, Conv_out_G, Conv_out_B, conv_ack
  );
endinterface

// File: rtl/conv_window_feeder.sv
// Walks every stride-1 window of an RGB feature map, streams k*k products
// plus a flush beat to the accumulator and stores the summed channel result.
module conv_window_feeder #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [9:0]    img_w,
  input  logic [9:0]    img_h,
  input  logic [3:0]    k,
  input  logic [DW-1:0] bias_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  conv_feed_if.master   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [9:0]    w_q, w_d;
  logic [9:0]    h_q, h_d;
  logic [3:0]    k_q, k_d;
  logic [DW-1:0] bias_q, bias_d;
  logic [9:0]    size_q, size_d;
  logic          err_q, err_d;
  logic [3:0]    kx_q, kx_d;
  logic [3:0]    ky_q, ky_d;
  logic [9:0]    col_q, col_d;
  logic [9:0]    row_q, row_d;
  logic [AW-1:0] org_q, org_d;
  logic [AW-1:0] fa_q, fa_d;
  logic [AW-1:0] wa_q, wa_d;
  logic          flush_q, flush_d;
  logic          en_q, en_d;
  logic          fl_q, fl_d;
  logic          rl_q, rl_d;
  logic [AW-1:0] win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [31:0]   rd_q, rd_d;

  logic [9:0]    k10, kin10;
  logic [AW-1:0] k_ext, w_ext, col_ext;

  assign k10     = {6'd0, k_q};
  assign kin10   = {6'd0, k};
  assign k_ext   = {{(AW-4){1'b0}}, k_q};
  assign w_ext   = {{(AW-10){1'b0}}, w_q};
  assign col_ext = {{(AW-10){1'b0}}, col_q};

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    k_d     = k_q;
    bias_d  = bias_q;
    size_d  = size_q;
    err_d   = err_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    col_d   = col_q;
    row_d   = row_q;
    org_d   = org_q;
    fa_d    = fa_q;
    wa_d    = wa_q;
    flush_d = flush_q;
    win_d   = win_q;
    ra_d    = ra_q;
    rd_d    = rd_q;
    we_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d     = img_w;
          h_d     = img_h;
          k_d     = k;
          bias_d  = bias_in;
          size_d  = kin10 * kin10 + 10'd1;
          err_d   = 1'b0;
          kx_d    = '0;
          ky_d    = '0;
          col_d   = '0;
          row_d   = '0;
          org_d   = '0;
          fa_d    = '0;
          wa_d    = '0;
          flush_d = 1'b0;
          win_d   = '0;
          if (k == 4'd0 || kin10 > img_w || kin10 > img_h) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!flush_q) begin
          if (kx_q == k_q - 4'd1) begin
            kx_d = '0;
            if (ky_q == k_q - 4'd1) begin
              flush_d = 1'b1;
              fa_d    = '0;
              wa_d    = '0;
            end else begin
              ky_d = ky_q + 4'd1;
              fa_d = fa_q - (k_ext - AW'(1)) + w_ext;
              wa_d = wa_q + AW'(1);
            end
          end else begin
            kx_d = kx_q + 4'd1;
            fa_d = fa_q + AW'(1);
            wa_d = wa_q + AW'(1);
          end
        end else begin
          // Flush slot: step to the next window origin.
          flush_d = 1'b0;
          kx_d    = '0;
          ky_d    = '0;
          wa_d    = '0;
          if (col_q == w_q - k10) begin
            col_d = '0;
            if (row_q == h_q - k10) begin
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + 10'd1;
              org_d = org_q - col_ext + w_ext;
            end
          end else begin
            col_d = col_q + 10'd1;
            org_d = org_q + AW'(1);
          end
          fa_d = (state_d == S_DRAIN) ? '0 : org_d;
        end
      end
      S_DRAIN: begin
        if (!en_q) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    en_d = (state_q == S_ISSUE);
    fl_d = en_d && flush_q;
    rl_d = en_d && !flush_q;

    // Ack must coincide with a flush beat; anything else is a protocol error.
    if (en_q && fl_q) begin
      win_d = win_q + AW'(1);
      if (bus.conv_ack) begin
        we_d = 1'b1;
        ra_d = win_q;
        rd_d = bus.Conv_out_R + bus.Conv_out_G + bus.Conv_out_B;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.conv_ack) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      k_q     <= '0;
      bias_q  <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
      kx_q    <= '0;
      ky_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      org_q   <= '0;
      fa_q    <= '0;
      wa_q    <= '0;
      flush_q <= 1'b0;
      en_q    <= 1'b0;
      fl_q    <= 1'b0;
      rl_q    <= 1'b0;
      win_q   <= '0;
      we_q    <= 1'b0;
      ra_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      k_q     <= k_d;
      bias_q  <= bias_d;
      size_q  <= size_d;
      err_q   <= err_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      col_q   <= col_d;
      row_q   <= row_d;
      org_q   <= org_d;
      fa_q    <= fa_d;
      wa_q    <= wa_d;
      flush_q <= flush_d;
      en_q    <= en_d;
      fl_q    <= fl_d;
      rl_q    <= rl_d;
      win_q   <= win_d;
      we_q    <= we_d;
      ra_q    <= ra_d;
      rd_q    <= rd_d;
    end
  end

  assign busy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done = (state_q == S_FINISH);
  assign err  = err_q;

  assign bus.fm_addr  = fa_q;
  assign bus.w_addr   = wa_q;
  assign bus.en       = en_q;
  assign bus.Size     = size_q;
  assign bus.Bias     = bias_q;
  assign bus.res_we   = we_q;
  assign bus.res_addr = ra_q;
  assign bus.res_data = rd_q;

  // Memory data arrives in the beat cycle, so the beat muxes it directly.
  assign bus.D_in_R   = rl_q ? bus.fm_data[3*DW-1:2*DW] : '0;
  assign bus.D_in_G   = rl_q ? bus.fm_data[2*DW-1:DW]   : '0;
  assign bus.D_in_B   = rl_q ? bus.fm_data[DW-1:0]      : '0;
  assign bus.Weight_R = rl_q ? bus.w_data[3*DW-1:2*DW]  : '0;
  assign bus.Weight_G = rl_q ? bus.w_data[2*DW-1:DW]    : '0;
  assign bus.Weight_B = rl_q ? bus.w_data[DW-1:0]       : '0;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench: memories plus a behavioural accumulator around the feeder; a
// frame-level timeline model is compared against the outputs every cycle.
module tb_conv_window_feeder;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MAXT = 4096;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [9:0] img_w, img_h;
  logic [3:0] k;
  logic [DW-1:0] bias_in;
  logic busy, done, err;

  conv_feed_if #(.DW(DW), .AW(AW)) bus ();

  conv_window_feeder #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .img_w(img_w), .img_h(img_h), .k(k),
    .bias_in(bias_in), .busy(busy), .done(done),
    .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [47:0] fm_mem [256];
  logic [47:0] w_mem [256];
  always @(posedge clk) begin
    bus.fm_data <= fm_mem[bus.fm_addr[7:0]];
    bus.w_data  <= w_mem[bus.w_addr[7:0]];
  end

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input int t,
                     input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s t=%0d got %0h exp %0h", nm, t, a, e);
    end
  endtask

  function automatic logic [15:0] ch(input logic [47:0] v, input int i);
    return v[47-16*i -: 16];
  endfunction

  // Behavioural accumulator: sums products, acks on the Size-th beat.
  bit inject = 0, drop = 0;
  int acnt = 0, awin = 0;
  logic [31:0] ar, ag, ab;
  always @(negedge clk) begin
    bus.conv_ack = 1'b0;
    if (!bus.en) begin
      acnt = 0; awin = 0; ar = 0; ag = 0; ab = 0;
    end else if (acnt == int'(bus.Size) - 1) begin
      bus.conv_ack   = !(drop && awin == 0);
      bus.Conv_out_R = ar + 32'(bus.Bias);
      bus.Conv_out_G = ag + 32'(bus.Bias);
      bus.Conv_out_B = ab + 32'(bus.Bias);
      acnt = 0; ar = 0; ag = 0; ab = 0;
      awin++;
    end else begin
      ar += 32'(bus.D_in_R) * 32'(bus.Weight_R);
      ag += 32'(bus.D_in_G) * 32'(bus.Weight_G);
      ab += 32'(bus.D_in_B) * 32'(bus.Weight_B);
      if (inject && acnt == 0 && awin == 0) bus.conv_ack = 1'b1;
      acnt++;
    end
  end

  logic [47:0] wlog [$];
  int encnt = 0;
  always @(negedge clk) begin
    if (bus.res_we) wlog.push_back({bus.res_addr, bus.res_data});
    if (bus.en) encnt++;
  end

  // Expected timeline, indexed by cycles after the start cycle.
  bit e_en [MAXT], e_real [MAXT], e_we [MAXT];
  bit e_done [MAXT], e_busy [MAXT], e_err [MAXT];
  logic [15:0] e_fa [MAXT], e_wa [MAXT], e_ra [MAXT];
  logic [15:0] e_d [MAXT][3], e_w [MAXT][3];
  logic [31:0] e_rd [MAXT];
  logic [9:0]  e_size;
  logic [15:0] e_bias;
  int tend = 0;
  int s0 = 0;
  bit chk_on = 0;

  task automatic build(input int w, input int h, input int kq,
                       input int bias, input int mode);
    int nx, ny, nw, kk, bl, r, c, j, ts, tb, a, dn, err_from;
    logic [31:0] sum;
    logic [47:0] pix, wt;
    for (int t = 0; t < MAXT; t++) begin
      e_en[t] = 0; e_real[t] = 0; e_we[t] = 0;
      e_done[t] = 0; e_busy[t] = 0; e_err[t] = 0;
      e_fa[t] = 0; e_wa[t] = 0; e_ra[t] = 0; e_rd[t] = 0;
      for (int i = 0; i < 3; i++) begin
        e_d[t][i] = 0; e_w[t][i] = 0;
      end
    end
    e_size = 10'(kq * kq + 1);
    e_bias = 16'(bias);
    if (kq == 0 || kq > w || kq > h) begin
      e_done[1] = 1;
      for (int t = 1; t < 4; t++) e_err[t] = 1;
      tend = 3;
      return;
    end
    nx = w - kq + 1; ny = h - kq + 1; nw = nx * ny;
    kk = kq * kq; bl = kk + 1;
    err_from = MAXT;
    if (mode == 1) err_from = 3;
    for (int n = 0; n < nw; n++) begin
      r = n / nx; c = n % nx;
      sum = 32'(3 * bias);
      for (int s = 0; s <= kk; s++) begin
        j = n * bl + s; ts = 1 + j; tb = 2 + j;
        e_en[tb] = 1;
        if (s < kk) begin
          a = (r + s / kq) * w + c + s % kq;
          e_real[ts] = 1; e_fa[ts] = 16'(a); e_wa[ts] = 16'(s);
          pix = fm_mem[a]; wt = w_mem[s];
          for (int i = 0; i < 3; i++) begin
            e_d[tb][i] = ch(pix, i); e_w[tb][i] = ch(wt, i);
            sum += 32'(ch(pix, i)) * 32'(ch(wt, i));
          end
        end else if (mode == 2 && n == 0) begin
          err_from = tb + 1;
        end else begin
          e_we[tb+1] = 1; e_ra[tb+1] = 16'(n); e_rd[tb+1] = sum;
        end
      end
    end
    dn = nw * bl + 3;
    e_done[dn] = 1;
    for (int t = 1; t < dn; t++) e_busy[t] = 1;
    tend = dn + 1;
    for (int t = err_from; t <= tend; t++) e_err[t] = 1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      int t;
      t = cyc - s0;
      if (t >= 1 && t <= tend) begin
        chk("en", t, 32'(bus.en), 32'(e_en[t]));
        chk("busy", t, 32'(busy), 32'(e_busy[t]));
        chk("done", t, 32'(done), 32'(e_done[t]));
        chk("err", t, 32'(err), 32'(e_err[t]));
        chk("size", t, 32'(bus.Size), 32'(e_size));
        chk("bias", t, 32'(bus.Bias), 32'(e_bias));
        chk("we", t, 32'(bus.res_we), 32'(e_we[t]));
        chk("d_r", t, 32'(bus.D_in_R), 32'(e_d[t][0]));
        chk("d_g", t, 32'(bus.D_in_G), 32'(e_d[t][1]));
        chk("d_b", t, 32'(bus.D_in_B), 32'(e_d[t][2]));
        chk("w_r", t, 32'(bus.Weight_R), 32'(e_w[t][0]));
        chk("w_g", t, 32'(bus.Weight_G), 32'(e_w[t][1]));
        chk("w_b", t, 32'(bus.Weight_B), 32'(e_w[t][2]));
        if (e_real[t]) begin
          chk("fm_addr", t, 32'(bus.fm_addr), 32'(e_fa[t]));
          chk("w_addr", t, 32'(bus.w_addr), 32'(e_wa[t]));
        end
        if (e_we[t]) begin
          chk("res_addr", t, 32'(bus.res_addr), 32'(e_ra[t]));
          chk("res_data", t, bus.res_data, e_rd[t]);
        end
      end
    end
  end

  task automatic frame(input int w, input int h, input int kq,
                       input int bias, input int mode, input bit restart);
    inject = (mode == 1);
    drop   = (mode == 2);
    @(negedge clk);
    build(w, h, kq, bias, mode);
    s0 = cyc;
    wlog.delete();
    encnt = 0;
    start = 1; img_w = 10'(w); img_h = 10'(h);
    k = 4'(kq); bias_in = 16'(bias);
    chk_on = 1;
    @(negedge clk);
    start = 0;
    img_w = 10'($urandom); img_h = 10'($urandom);
    k = 4'($urandom); bias_in = 16'($urandom);
    if (restart) begin
      repeat (3) @(negedge clk);
      start = 1; img_w = 2; img_h = 2; k = 1;
      @(negedge clk);
      start = 0;
    end
    while (cyc - s0 <= tend) @(negedge clk);
    chk_on = 0;
    inject = 0;
    drop = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 0, 32'(busy), 0);
    chk({tag, "_done"}, 0, 32'(done), 0);
    chk({tag, "_err"}, 0, 32'(err), 0);
    chk({tag, "_en"}, 0, 32'(bus.en), 0);
    chk({tag, "_we"}, 0, 32'(bus.res_we), 0);
    chk({tag, "_fa"}, 0, 32'(bus.fm_addr), 0);
    chk({tag, "_wa"}, 0, 32'(bus.w_addr), 0);
    chk({tag, "_d"}, 0, 32'({bus.D_in_R, bus.D_in_G}), 0);
    chk({tag, "_db"}, 0, 32'(bus.D_in_B), 0);
    chk({tag, "_w"}, 0, 32'({bus.Weight_R, bus.Weight_G}), 0);
    chk({tag, "_wb"}, 0, 32'(bus.Weight_B), 0);
    chk({tag, "_bias"}, 0, 32'(bus.Bias), 0);
    chk({tag, "_size"}, 0, 32'(bus.Size), 0);
    chk({tag, "_ra"}, 0, 32'(bus.res_addr), 0);
    chk({tag, "_rd"}, 0, bus.res_data, 0);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 256; i++) begin
      fm_mem[i] = {16'($urandom), 16'($urandom), 16'($urandom)};
      w_mem[i]  = {16'($urandom), 16'($urandom), 16'($urandom)};
    end
  endtask

  bit saw;
  int kr;
  logic [31:0] t2_exp [4];

  initial begin
    rst = 1; start = 0; img_w = 0; img_h = 0; k = 0; bias_in = 0;
    repeat (3) @(negedge clk);
    check_zero("rst0");
    rst = 0;

    // Single window, R=1 everywhere, all weights 1.
    for (int i = 0; i < 256; i++) begin
      fm_mem[i] = {16'd1, 16'd0, 16'd0};
      w_mem[i]  = {16'd1, 16'd1, 16'd1};
    end
    frame(3, 3, 3, 0, 0, 0);
    chk("t1_size", 0, 32'(bus.Size), 10);
    chk("t1_en", 0, encnt, 10);
    chk("t1_nwr", 0, wlog.size(), 1);
    if (wlog.size() > 0) chk("t1_data", 0, wlog[0][31:0], 9);

    // Window ordering: R = pixel index, only the R weight set.
    for (int i = 0; i < 256; i++) begin
      fm_mem[i] = {16'(i), 16'd0, 16'd0};
      w_mem[i]  = {16'd1, 16'd0, 16'd0};
    end
    frame(4, 4, 3, 0, 0, 0);
    t2_exp[0] = 45; t2_exp[1] = 54; t2_exp[2] = 81; t2_exp[3] = 90;
    chk("t2_en", 0, encnt, 40);
    chk("t2_nwr", 0, wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("t2_addr", i, 32'(wlog[i][47:32]), i);
      chk("t2_data", i, wlog[i][31:0], t2_exp[i]);
    end

    // Minimum kernel.
    rand_mem();
    frame(2, 2, 1, 7, 0, 0);
    chk("k1_size", 0, 32'(bus.Size), 2);
    chk("k1_en", 0, encnt, 8);
    chk("k1_nwr", 0, wlog.size(), 4);

    // Illegal parameters.
    frame(4, 4, 5, 3, 0, 0);
    chk("ill5_en", 0, encnt, 0);
    chk("ill5_err", 0, 32'(err), 1);
    frame(4, 4, 0, 3, 0, 0);
    chk("ill0_en", 0, encnt, 0);
    chk("ill0_err", 0, 32'(err), 1);

    // Stray ack on a real beat, then a clean frame clears err.
    rand_mem();
    frame(5, 4, 2, 11, 1, 0);
    chk("inj_err", 0, 32'(err), 1);
    chk("inj_nwr", 0, wlog.size(), 12);
    frame(3, 3, 2, 1, 0, 0);
    chk("clr_err", 0, 32'(err), 0);

    // Missing ack on the first flush beat.
    frame(4, 3, 2, 5, 2, 0);
    chk("drop_err", 0, 32'(err), 1);
    chk("drop_nwr", 0, wlog.size(), 5);

    // Start while busy, and the largest kernel.
    frame(5, 5, 3, 9, 0, 1);
    frame(11, 12, 11, 2, 0, 0);
    chk("k11_size", 0, 32'(bus.Size), 122);

    for (int it = 0; it < 12; it++) begin
      rand_mem();
      kr = $urandom_range(0, 5);
      frame($urandom_range(1, 8), $urandom_range(1, 8), kr,
            $urandom_range(0, 65535), 0, 0);
    end

    // Reset in the middle of a window.
    @(negedge clk);
    start = 1; img_w = 6; img_h = 6; k = 3; bias_in = 4;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_zero("rst1");
    rst = 0;
    saw = 0;
    repeat (60) begin
      @(negedge clk);
      saw |= done | bus.en;
    end
    chk("rst_quiet", 0, 32'(saw), 0);

    // Start together with reset: reset wins.
    @(negedge clk);
    start = 1; rst = 1; img_w = 3; img_h = 3; k = 2;
    @(negedge clk);
    start = 0; rst = 0;
    chk("sr_busy", 0, 32'(busy), 0);
    saw = 0;
    repeat (6) begin
      @(negedge clk);
      saw |= busy | bus.en | done;
    end
    chk("sr_quiet", 0, 32'(saw), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
